// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/sub, one SEG_WIDTH segment per stage, carry rippling stage to stage; ADDSUB_SAT_EN clamps the sum on overflow.
// Latency: STAGES (= WIDTH/SEG_WIDTH) register stages, one result per cycle at full rate.
// Backpressure: a stage holds while it and every stage after it are full and out_ready is low; in_ready follows combinationally.
module pipelined_addsub #(
    parameter int WIDTH     = 16,
    parameter int SEG_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int STAGES = WIDTH / SEG_WIDTH;
    localparam int LAST   = STAGES - 1;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic              ovf_q, ovf_d;

    logic              src_v, src_c, tail_full;
    logic [WIDTH-1:0]  src_a, src_b, src_s;
    logic [SEG_WIDTH:0] seg;

    // Stage k may move iff the output drains or some stage from k onward has a hole.
    always_comb begin
        adv       = '0;
        tail_full = 1'b1;
        for (int k = 0; k < STAGES; k++) begin
            tail_full = 1'b1;
            for (int j = k; j < STAGES; j++) begin
                tail_full = tail_full & vld_q[j];
            end
            adv[k] = out_ready || !tail_full;
        end
    end

    always_comb begin
        vld_d = vld_q;
        c_d   = c_q;
        a_d   = a_q;
        b_d   = b_q;
        sum_d = sum_q;
        ovf_d = ovf_q;
        src_v = 1'b0;
        src_c = 1'b0;
        src_a = '0;
        src_b = '0;
        src_s = '0;
        seg   = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                src_v = in_valid;
                src_a = a;
                src_b = b ^ {WIDTH{op_sub}};
                src_c = cin ^ op_sub;
                src_s = '0;
            end else begin
                src_v = vld_q[(k == 0) ? 0 : k - 1];
                src_a = a_q[(k == 0) ? 0 : k - 1];
                src_b = b_q[(k == 0) ? 0 : k - 1];
                src_c = c_q[(k == 0) ? 0 : k - 1];
                src_s = sum_q[(k == 0) ? 0 : k - 1];
            end
            seg = {1'b0, src_a[k*SEG_WIDTH +: SEG_WIDTH]}
                + {1'b0, src_b[k*SEG_WIDTH +: SEG_WIDTH]}
                + {{SEG_WIDTH{1'b0}}, src_c};
            if (adv[k]) begin
                vld_d[k] = src_v;
                if (src_v) begin
                    a_d[k]   = src_a;
                    b_d[k]   = src_b;
                    c_d[k]   = seg[SEG_WIDTH];
                    sum_d[k] = src_s;
                    sum_d[k][k*SEG_WIDTH +: SEG_WIDTH] = seg[SEG_WIDTH-1:0];
                    if (k == LAST) begin
                        ovf_d = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                                (sum_d[k][WIDTH-1] != src_a[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
                        if (ovf_d) begin
                            sum_d[k] = src_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                      : {1'b0, {(WIDTH-1){1'b1}}};
                        end
`else
`endif
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld_q[LAST];
    assign sum       = sum_q[LAST];
    assign cout      = c_q[LAST];
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Randomised and directed bench for pipelined_addsub against an integer-arithmetic reference model.
module tb_pipelined_addsub;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, cin, op_sub;
    logic         out_valid, out_ready, cout, overflow;
    logic [W-1:0] a, b, sum;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(16), .SEG_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op_sub(op_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow)
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    res_t exp_q[$];
    res_t got_q[$];
    int   acc_cyc[$];
    int   got_cyc[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mc, input logic msub);
        res_t        o;
        int          ires;
        logic [W:0]  r;
        if (!msub) begin
            r    = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
            o.c  = r[W];
            ires = $signed(ma) + $signed(mb) + int'(mc);
        end else begin
            r    = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mc};
            o.c  = (int'(ma) >= int'(mb) + int'(mc));
            ires = $signed(ma) - $signed(mb) - int'(mc);
        end
        o.s = r[W-1:0];
        o.v = (ires > 32767) || (ires < -32768);
`ifdef ADDSUB_SAT_EN
        if (o.v) o.s = (ires > 0) ? 16'h7FFF : 16'h8000;
`endif
        return o;
    endfunction

    // Records handshakes just before the coming edge, then returns at the next negedge.
    task automatic cycle();
        #1;
        if (in_valid && in_ready && !rst) begin
            exp_q.push_back(model(a, b, cin, op_sub));
            acc_cyc.push_back(cyc);
        end
        if (out_valid && out_ready && !rst) begin
            got_q.push_back({sum, cout, overflow});
            got_cyc.push_back(cyc);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive_rand();
        in_valid = 1'b1;
        a        = 16'($urandom);
        b        = 16'($urandom);
        cin      = 1'($urandom_range(0, 1));
        op_sub   = 1'($urandom_range(0, 1));
    endtask

    task automatic idle();
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
    endtask

    task automatic clear_q();
        exp_q.delete(); got_q.delete(); acc_cyc.delete(); got_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
        @(negedge clk);
        cycle(); cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (sum !== 16'h0) begin errors++; $display("FAIL reset_sum got=%h want=0000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b want=0", cout); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        rst = 1'b0;
        clear_q();
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4] = '{16'h7FFF, 16'hFFFF, 16'h0005, 16'h8000};
        logic [W-1:0] vb [4] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001};
        logic         vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`ifdef ADDSUB_SAT_EN
        logic [W-1:0] es [4] = '{16'h7FFF, 16'h0000, 16'hFFFE, 16'h8000};
`else
        logic [W-1:0] es [4] = '{16'h8000, 16'h0000, 16'hFFFE, 16'h7FFF};
`endif
        logic         ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic         ev [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int           n;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a = va[i]; b = vb[i]; cin = 1'b0; op_sub = vs[i];
            cycle();
            idle();
            n = 1;
            while (!out_valid && n < 12) begin
                cycle();
                n++;
            end
            checks++; if (n !== 4) begin errors++; $display("FAIL dir%0d_latency got=%0d want=4", i, n); end
            checks++; if (sum !== es[i]) begin errors++; $display("FAIL dir%0d_sum got=%h want=%h", i, sum, es[i]); end
            checks++; if (cout !== ec[i]) begin errors++; $display("FAIL dir%0d_cout got=%b want=%b", i, cout, ec[i]); end
            checks++; if (overflow !== ev[i]) begin errors++; $display("FAIL dir%0d_overflow got=%b want=%b", i, overflow, ev[i]); end
            cycle();
            clear_q();
        end
    endtask

    task automatic test_back_to_back();
        int   sent = 0;
        int   occ;
        logic stalled_prev = 1'b0;
        logic saw_full = 1'b0;
        logic acc;
        logic [W+2:0] held = '0;
        clear_q();
        idle();
        for (int t = 0; t < 60 && got_q.size() < 8; t++) begin
            if (sent < 8) begin
                if (!in_valid) drive_rand();
            end else begin
                idle();
            end
            out_ready = !(t >= 3 && t <= 6);
            #1;
            occ = exp_q.size() - got_q.size();
            checks++;
            if (in_ready !== ((occ < 4) || out_ready)) begin
                errors++; $display("FAIL b2b_in_ready t=%0d occ=%0d got=%b", t, occ, in_ready);
            end
            if (!in_ready) saw_full = 1'b1;
            if (stalled_prev) begin
                checks++;
                if ({out_valid, sum, cout, overflow} !== held) begin
                    errors++; $display("FAIL b2b_stall_hold t=%0d got=%h want=%h", t, {out_valid, sum, cout, overflow}, held);
                end
            end
            stalled_prev = out_valid && !out_ready;
            held = {out_valid, sum, cout, overflow};
            acc = in_valid && in_ready;
            cycle();
            if (acc) begin
                sent++;
                if (sent < 8) drive_rand(); else idle();
            end
        end
        checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL b2b_full got=%b want=1", saw_full); end
        checks++; if (got_q.size() !== 8) begin errors++; $display("FAIL b2b_count got=%0d want=8", got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL b2b_result%0d got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        idle();
        out_ready = 1'b1;
    endtask

    task automatic test_full_rate();
        clear_q();
        out_ready = 1'b1;
        for (int t = 0; t < 30; t++) begin
            if (t < 20) drive_rand(); else idle();
            #1;
            if (t < 20) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL rate_in_ready t=%0d got=%b want=1", t, in_ready); end
            end
            cycle();
        end
        checks++; if (got_q.size() !== 20) begin errors++; $display("FAIL rate_count got=%0d want=20", got_q.size()); end
        if (got_q.size() == 20 && exp_q.size() == 20) begin
            checks++;
            if (got_cyc[0] - acc_cyc[0] !== 4) begin
                errors++; $display("FAIL rate_latency got=%0d want=4", got_cyc[0] - acc_cyc[0]);
            end
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i] || got_cyc[i] !== got_cyc[0] + i) begin
                    errors++; $display("FAIL rate_result%0d got=%h@%0d want=%h@%0d", i, got_q[i], got_cyc[i], exp_q[i], got_cyc[0] + i);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            cycle();
        end
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid i=%0d got=%b want=0", i, out_valid); end
            cycle();
        end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL rstmid_stale got=%0d want=0", got_q.size()); end
        clear_q();
        drive_rand();
        cycle();
        idle();
        for (int i = 0; i < 10; i++) cycle();
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL rstmid_count got=%0d want=1", got_q.size()); end
        if (got_q.size() == 1 && exp_q.size() == 1) begin
            checks++;
            if (got_cyc[0] - acc_cyc[0] !== 4) begin
                errors++; $display("FAIL rstmid_latency got=%0d want=4", got_cyc[0] - acc_cyc[0]);
            end
            checks++;
            if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL rstmid_result got=%h want=%h", got_q[0], exp_q[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_full_rate();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
